// File: rtl/fp_addsub_arbiter.sv
// Round-robin front end sharing one multi-cycle FP add/sub core between two requesters.
// Optional FP_EXC_BYPASS_EN answers NaN and inf-inf operations without using the core.
module fp_addsub_arbiter #(
    parameter int WIDTH     = 32,
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = 23,
    parameter int TIMEOUT   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_invalid,
    output logic             rsp0_timeout,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_invalid,
    output logic             rsp1_timeout,
    output logic             core_start,
    output logic [WIDTH-1:0] core_a,
    output logic [WIDTH-1:0] core_b,
    output logic             core_op,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_result,
    input  logic             core_invalid
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WIDTH-1:0] QNAN =
        {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MANT_BITS-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_last;
    logic             r_gnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_op;
    logic [WIDTH-1:0] r_res;
    logic             r_inv;
    logic             r_to;
    logic [CW-1:0]    r_cnt;

    logic             w_gnt1;
    logic             w_acc;
    logic             w_expire;
    logic             w_bypass;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic             w_sel_op;

    // req1 wins only when alone or when req0 was served last
    assign w_gnt1   = req1_valid & (~req0_valid | ~r_last);
    assign w_acc    = (r_state == S_IDLE) & ~rst & (req0_valid | req1_valid);
    assign w_expire = (r_cnt == CW'(TIMEOUT - 1));
    assign w_sel_a  = w_gnt1 ? req1_a  : req0_a;
    assign w_sel_b  = w_gnt1 ? req1_b  : req0_b;
    assign w_sel_op = w_gnt1 ? req1_op : req0_op;

`ifdef FP_EXC_BYPASS_EN
    function automatic logic f_nan(input logic [WIDTH-1:0] x);
        return (&x[WIDTH-2:MANT_BITS]) & (|x[MANT_BITS-1:0]);
    endfunction

    function automatic logic f_inf(input logic [WIDTH-1:0] x);
        return (&x[WIDTH-2:MANT_BITS]) & ~(|x[MANT_BITS-1:0]);
    endfunction

    logic w_eff_sub;
    assign w_eff_sub = w_sel_a[WIDTH-1] ^ w_sel_b[WIDTH-1] ^ ~w_sel_op;
    assign w_bypass  = f_nan(w_sel_a) | f_nan(w_sel_b)
                     | (f_inf(w_sel_a) & f_inf(w_sel_b) & w_eff_sub);
`else
    assign w_bypass = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        core_start = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                req0_ready = ~rst & req0_valid & ~w_gnt1;
                req1_ready = ~rst & w_gnt1;
                if (w_acc) w_next = w_bypass ? S_RESP : S_ISSUE;
            end
            S_ISSUE: begin
                core_start = 1'b1;
                w_next     = S_WAIT;
            end
            S_WAIT: begin
                if (core_done || w_expire) w_next = S_RESP;
            end
            S_RESP: begin
                rsp0_valid = ~r_gnt;
                rsp1_valid = r_gnt;
                if (r_gnt ? rsp1_ready : rsp0_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_gnt   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= 1'b0;
            r_res   <= '0;
            r_inv   <= 1'b0;
            r_to    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_a    <= w_sel_a;
                        r_b    <= w_sel_b;
                        r_op   <= w_sel_op;
                        r_gnt  <= w_gnt1;
                        r_last <= w_gnt1;
                        if (w_bypass) begin
                            r_res <= QNAN;
                            r_inv <= 1'b1;
                            r_to  <= 1'b0;
                        end
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    // a done on the expiry cycle still returns the core result
                    if (core_done) begin
                        r_res <= core_result;
                        r_inv <= core_invalid;
                        r_to  <= 1'b0;
                    end else if (w_expire) begin
                        r_res <= QNAN;
                        r_inv <= 1'b1;
                        r_to  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_a       = r_a;
    assign core_b       = r_b;
    assign core_op      = r_op;
    assign rsp0_result  = r_res;
    assign rsp0_invalid = r_inv;
    assign rsp0_timeout = r_to;
    assign rsp1_result  = r_res;
    assign rsp1_invalid = r_inv;
    assign rsp1_timeout = r_to;
endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Bench for fp_addsub_arbiter: directed plus randomized operations against a
// behavioural model of grant order, core sequencing, watchdog and exception bypass.
module tb_fp_addsub_arbiter;
    localparam int TMO = 16;
    localparam logic [31:0] QNAN = 32'h7FC00000;
`ifdef FP_EXC_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_op;
    logic        req1_valid, req1_ready, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp0_invalid, rsp0_timeout;
    logic        rsp1_valid, rsp1_ready, rsp1_invalid, rsp1_timeout;
    logic [31:0] rsp0_result, rsp1_result;
    logic        core_start, core_op, core_done, core_invalid;
    logic [31:0] core_a, core_b, core_result;

    int          rem[2];
    logic [31:0] pa[2];
    logic [31:0] pb[2];
    logic        pop[2];
    int          last_g;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    assign req0_valid = (rem[0] > 0);
    assign req1_valid = (rem[1] > 0);
    assign req0_a = pa[0];
    assign req0_b = pb[0];
    assign req0_op = pop[0];
    assign req1_a = pa[1];
    assign req1_b = pb[1];
    assign req1_op = pop[1];

    fp_addsub_arbiter #(.WIDTH(32), .EXP_BITS(8), .MANT_BITS(23), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_invalid(rsp0_invalid),
        .rsp0_timeout(rsp0_timeout),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_invalid(rsp1_invalid),
        .rsp1_timeout(rsp1_timeout),
        .core_start(core_start), .core_a(core_a), .core_b(core_b),
        .core_op(core_op), .core_done(core_done),
        .core_result(core_result), .core_invalid(core_invalid)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int g);
        return (g == 1) ? req1_ready : req0_ready;
    endfunction

    function automatic logic rspv(input int g);
        return (g == 1) ? rsp1_valid : rsp0_valid;
    endfunction

    function automatic logic [31:0] rres(input int g);
        return (g == 1) ? rsp1_result : rsp0_result;
    endfunction

    function automatic logic rinv(input int g);
        return (g == 1) ? rsp1_invalid : rsp0_invalid;
    endfunction

    function automatic logic rto(input int g);
        return (g == 1) ? rsp1_timeout : rsp0_timeout;
    endfunction

    // IEEE rule: NaN operand, or inf op inf that is effectively a subtraction
    function automatic bit exc_op(input logic [31:0] a, input logic [31:0] b,
                                  input logic op);
        bit na, nb, ia, ib, sub;
        na  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nb  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        ia  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        ib  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        sub = op ? (a[31] != b[31]) : (a[31] == b[31]);
        return na || nb || (ia && ib && sub);
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 7))
            0: v = {v[31], 31'h7F800000};
            1: v = {v[31], 8'hFF, v[22:0] | 23'h1};
            default: ;
        endcase
        return v;
    endfunction

    // Serve one operation from IDLE: grant, issue, core reply (or none), response.
    // dat = WAIT cycle on which the core answers, <0 = never.
    task automatic serve(input int dat, input logic [31:0] cres, input logic cinv,
                         input int hold, input bit poke, input bit stray);
        int g, o;
        logic [31:0] a, b, er;
        logic op, ei, et;
        bit byp;
        if (rem[0] > 0 && rem[1] > 0) g = 1 - last_g;
        else if (rem[0] > 0) g = 0;
        else g = 1;
        o = 1 - g;
        #1;
        chk("ready_granted", rdy(g), 1);
        chk("ready_other", rdy(o), 0);
        a = pa[g];
        b = pb[g];
        op = pop[g];
        byp = BYP && exc_op(a, b, op);
        @(posedge clk);
        last_g = g;
        @(negedge clk);
        rem[g]--;
        pa[g] = $urandom;
        pb[g] = $urandom;
        pop[g] = 1'($urandom);
        if (poke) rem[o] = 1;
        if (byp) begin
            er = QNAN;
            ei = 1'b1;
            et = 1'b0;
            chk("bypass_no_start", core_start, 0);
        end else begin
            chk("start_pulse", core_start, 1);
            chk("core_a", core_a, a);
            chk("core_b", core_b, b);
            chk("core_op", core_op, op);
            core_done = stray;
            core_result = $urandom;
            core_invalid = 1'b1;
            @(negedge clk);
            core_done = 1'b0;
            chk("start_single", core_start, 0);
            for (int k = 0; k < TMO; k++) begin
                chk("busy_rsp_g", rspv(g), 0);
                chk("busy_rsp_o", rspv(o), 0);
                if (k == dat) begin
                    core_done = 1'b1;
                    core_result = cres;
                    core_invalid = cinv;
                    @(negedge clk);
                    core_done = 1'b0;
                    core_result = $urandom;
                    break;
                end
                @(negedge clk);
            end
            if (dat >= 0 && dat < TMO) begin
                er = cres;
                ei = cinv;
                et = 1'b0;
            end else begin
                er = QNAN;
                ei = 1'b1;
                et = 1'b1;
            end
        end
        #1;
        for (int h = 0; h <= hold; h++) begin
            chk("rsp_valid", rspv(g), 1);
            chk("rsp_other", rspv(o), 0);
            chk("rsp_result", rres(g), er);
            chk("rsp_invalid", rinv(g), ei);
            chk("rsp_timeout", rto(g), et);
            chk("resp_ready0", req0_ready, 0);
            chk("resp_ready1", req1_ready, 0);
            if (h < hold) @(negedge clk);
        end
        if (g == 1) rsp1_ready = 1'b1;
        else rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        chk("rsp_dropped", rspv(g), 0);
    endtask

    initial begin
        rst = 1'b1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        core_done = 1'b0;
        core_result = '0;
        core_invalid = 1'b0;
        rem[0] = 0;
        rem[1] = 0;
        for (int i = 0; i < 2; i++) begin
            pa[i] = $urandom;
            pb[i] = $urandom;
            pop[i] = 1'b0;
        end
        last_g = 1;
        repeat (2) @(negedge clk);
        rem[0] = 1;
        #1;
        chk("reset_ready0", req0_ready, 0);
        chk("reset_rsp0", rsp0_valid, 0);
        chk("reset_rsp1", rsp1_valid, 0);
        chk("reset_start", core_start, 0);
        chk("reset_core_a", core_a, 0);
        chk("reset_core_b", core_b, 0);
        chk("reset_core_op", core_op, 0);
        chk("reset_result", rsp0_result, 0);
        chk("reset_flags", {rsp0_invalid, rsp0_timeout, rsp1_invalid, rsp1_timeout}, 0);
        rem[0] = 0;
        rst = 1'b0;
        @(negedge clk);

        // contention from reset: both held for two operations each
        rem[0] = 2;
        rem[1] = 2;
        for (int i = 0; i < 4; i++)
            serve($urandom_range(0, 5), $urandom, 1'($urandom), $urandom_range(0, 2), 0, 0);

        // single request 1.0 + 2.0
        pa[0] = 32'h3F800000;
        pb[0] = 32'h40000000;
        pop[0] = 1'b1;
        rem[0] = 1;
        serve(2, 32'h40400000, 1'b0, 0, 0, 0);

        // backpressure on rsp1 with req0 waiting
        rem[1] = 1;
        serve(1, $urandom, 1'b0, 5, 1, 0);
        serve(0, $urandom, 1'b0, 0, 0, 0);

        // watchdog expiry, then done exactly on the expiry cycle
        rem[0] = 1;
        serve(-1, 32'h0, 1'b0, 1, 0, 0);
        rem[1] = 1;
        serve(TMO - 1, 32'h12345678, 1'b0, 0, 0, 0);

        // inf - inf
        pa[1] = 32'h7F800000;
        pb[1] = 32'h7F800000;
        pop[1] = 1'b0;
        rem[1] = 1;
        serve(2, 32'h7FC00001, 1'b1, 0, 0, 0);

        // randomized traffic, stray done during ISSUE
        for (int i = 0; i < 24; i++) begin
            if (rem[0] == 0 && rem[1] == 0) begin
                case ($urandom_range(0, 2))
                    0: rem[0] = 1;
                    1: rem[1] = 1;
                    default: begin
                        rem[0] = 1;
                        rem[1] = 1;
                    end
                endcase
                for (int r = 0; r < 2; r++) begin
                    pa[r] = rnd_fp();
                    pb[r] = rnd_fp();
                    pop[r] = 1'($urandom);
                end
            end
            serve($urandom_range(0, 6), $urandom, 1'($urandom),
                  $urandom_range(0, 3), 0, 1'($urandom));
        end
        while (rem[0] > 0 || rem[1] > 0)
            serve(1, $urandom, 1'b0, 0, 0, 0);

        // reset in the middle of WAIT, late core_done ignored
        rem[0] = 1;
        pa[0] = 32'h40A00000;
        pb[0] = 32'h3F800000;
        @(posedge clk);
        @(negedge clk);
        rem[0] = 0;
        chk("mid_start", core_start, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        core_done = 1'b1;
        core_result = 32'h3F800000;
        core_invalid = 1'b0;
        chk("rst_core_a", core_a, 0);
        @(negedge clk);
        core_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_no_rsp0", rsp0_valid, 0);
            chk("rst_no_rsp1", rsp1_valid, 0);
            chk("rst_no_start", core_start, 0);
            @(negedge clk);
        end
        last_g = 1;
        rem[0] = 1;
        rem[1] = 1;
        serve(3, $urandom, 1'b0, 0, 0, 0);
        serve(2, $urandom, 1'b0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
